// File: rtl/mul_pkg.sv
// Shared types and sizing for the sequential 16x16 multiplier.
package mul_pkg;

  localparam int MUL_W     = 16;
  localparam int PROD_W    = 32;
  localparam int CNT_W     = 4;
  localparam int MUL_STEPS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_seq_if.sv
// Operand/product handshake bundle for the MUL execution unit.
interface mul_seq_if;
  import mul_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [MUL_W-1:0]  in_a;
  logic [MUL_W-1:0]  in_b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] out_prod;
  logic              busy;

  // Issuing side (ALU dispatch / testbench).
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod, busy
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod, busy
  );

endinterface

// File: rtl/mul_seq_adder.sv
// 16-bit carry-lookahead adder: 4-bit groups with group generate/propagate
// so the carry into each group does not ripple through the previous one.
module Adder (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;

  assign g = A & B;
  assign p = A ^ B;

  // Carry lookahead: in-group carries from bit g/p, group carry from gg/gp.
  always_comb begin
    c  = '0;
    gg = '0;
    gp = '0;
    c[0] = Cin;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      c[4*k+1] = g[4*k]   | (p[4*k]   & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
    end
  end

  assign S    = p ^ c[15:0];
  assign Cout = c[16];

endmodule

// File: rtl/mul_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier (MUL execution unit).
// One Adder is reused for 16 steps; {hi,lo} shifts right each step while
// lo[0] selects whether the multiplicand is added into hi.
// Optional early termination: define MUL_SEQ_EARLY_TERM_EN.
//
// state | meaning
// IDLE  | ready for operands
// RUN   | one shift-and-add step per clock
// DONE  | product valid, held until out_ready
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_W  // only 16 is legal; Adder is fixed width
) (
  input  logic        clk,
  input  logic        reset,
  mul_seq_if.slave    bus
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   prod_q;

  logic                 accept;
  logic                 last_step;
  logic                 early_done;
  logic [2*WIDTH-1:0]   early_prod;
  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [WIDTH-1:0]     step_hi;
  logic [WIDTH-1:0]     step_lo;

  assign accept    = bus.in_valid && (state_q == IDLE);
  assign last_step = (cnt_q == CNT_W'(MUL_STEPS - 1));
  assign add_b     = lo_q[0] ? mcand_q : '0;

  Adder u_adder (
    .A    (hi_q),
    .B    (add_b),
    .Cin  (1'b0),
    .S    (sum),
    .Cout (cout)
  );

  // Carry-out becomes the new hi MSB; the bit shifted out of the sum
  // enters lo from the top as a finished product bit.
  assign step_hi = {cout, sum[WIDTH-1:1]};
  assign step_lo = {sum[0], lo_q[WIDTH-1:1]};

`ifdef MUL_SEQ_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
  logic [4:0]       align_sh;

  // Remaining multiplier bits are lo[15-cnt:0]; if they are all zero the
  // rest of the run would only shift, so align the partial product at once.
  always_comb begin
    rem_mask   = {WIDTH{1'b1}} >> cnt_q;
    align_sh   = 5'(WIDTH) - {1'b0, cnt_q};
    early_done = ((lo_q & rem_mask) == '0);
    early_prod = {hi_q, lo_q} >> align_sh;
  end
`else
  assign early_done = 1'b0;
  assign early_prod = '0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (early_done || last_step) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.out_prod  = prod_q;
  end

  // Datapath: operand load on accept, one step per RUN cycle, product capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else if (accept) begin
      mcand_q <= bus.in_a;
      hi_q    <= '0;
      lo_q    <= bus.in_b;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      if (early_done) begin
        prod_q <= early_prod;
      end else begin
        hi_q  <= step_hi;
        lo_q  <= step_lo;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_step) prod_q <= {step_hi, step_lo};
      end
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed + random bench for mul_seq; products and latency come from plain
// arithmetic on the operands.
module tb_mul_seq;
  import mul_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mul_seq_if bus ();

  mul_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Edges from accept until out_valid is first seen high.
  function automatic int exp_latency(input logic [15:0] b);
`ifdef MUL_SEQ_EARLY_TERM_EN
    int msb;
    msb = -1;
    for (int i = 0; i < 16; i++) if (b[i]) msb = i;
    if (msb < 0) return 1;
    return (msb + 2 > 16) ? 16 : msb + 2;
`else
    return 16;
`endif
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready === 1'b1) return;
      @(posedge clk); #1;
    end
    chk("wait_in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
  endtask

  // One full operation; hold = cycles out_ready stays low once valid,
  // pulse = drive stray in_valid with other operands during the hold.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input int hold, input bit pulse, input string tag);
    logic [31:0] exp_p;
    int          lat;
    bit          ready_low;
    exp_p = 32'(a) * 32'(b);
    wait_ready();
    bus.out_ready = (hold == 0);
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 16'($urandom);
    bus.in_b      = 16'($urandom);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    lat       = 99;
    ready_low = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.in_ready !== 1'b0) ready_low = 1'b0;
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_latency(b)));
    chk({tag, "_prod"}, bus.out_prod, exp_p);
    chk({tag, "_in_ready_low"}, {31'd0, ready_low}, 32'd1);
    for (int h = 0; h < hold; h++) begin
      if (pulse) begin
        bus.in_valid = 1'b1;
        bus.in_a     = 16'hFFFF;
        bus.in_b     = 16'h0003;
      end
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, "_hold_prod"}, bus.out_prod, exp_p);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    if (hold > 0) begin
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    chk({tag, "_idle_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, "_idle_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          sel, hold;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_prod", bus.out_prod, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_op(16'h00FF, 16'h0101, 0, 1'b0, "ff_x_101");
    do_op(16'hFFFF, 16'hFFFF, 0, 1'b0, "ffff_sq");
    do_op(16'h1234, 16'h0002, 5, 1'b1, "hold5");

    // Abort mid-run with an asynchronous reset.
    wait_ready();
    bus.in_a     = 16'hABCD;
    bus.in_b     = 16'h0003;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_abort_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_prod", bus.out_prod, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    do_op(16'h0005, 16'h0007, 0, 1'b0, "after_abort");

    do_op(16'h0000, 16'hFFFF, 0, 1'b0, "zero_a");
    do_op(16'hFFFF, 16'h0000, 0, 1'b0, "zero_b");
    do_op(16'h0005, 16'h0001, 0, 1'b0, "b_one");
    do_op(16'h0003, 16'h8000, 1, 1'b0, "b_msb");

    for (int i = 0; i < 1000; i++) begin
      ra   = 16'($urandom);
      sel  = $urandom_range(0, 3);
      case (sel)
        0:       rb = 16'($urandom);
        1:       rb = 16'($urandom >> $urandom_range(0, 31));
        2:       rb = 16'(32'd1 << $urandom_range(0, 15));
        default: rb = 16'($urandom_range(0, 3));
      endcase
      hold = $urandom_range(0, 2);
      do_op(ra, rb, hold, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
